fixed_multiplier: RTL and testbench
===================================

FIXED_MULTIPLIER -- requirements
Module: fixed_multiplier

Interface
REQ-001 The module SHALL have no parameters; widths are fixed at an 8-bit quotient, 4-bit divisor, 4-bit remainder and 12-bit dividend.
REQ-002 The ports SHALL be, clock and reset first, one per line as follows.
REQ-003 clock  in  1  Single clock; all state updates on its rising edge.
REQ-004 resetn  in  1  Synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 start  in  1  Request; sampled in IDLE or DONE only.
REQ-006 inQuotient  in  8  Multiplicand; latched on an accepted start.
REQ-007 inDivisor  in  4  Multiplier; latched on an accepted start.
REQ-008 inRemainder  in  4  Addend; latched on an accepted start; used only under REMAINDER_ADD_EN.
REQ-009 busy  out  1  High while in RUN.
REQ-010 done  out  1  One-cycle pulse when Dividend becomes valid.
REQ-011 Dividend  out  12  Reconstructed dividend; held stable from done until the next accepted start.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 Transitions: IDLE->RUN on start=1; RUN->DONE after the 4th RUN edge; DONE->RUN on start=1; DONE->IDLE on start=0.
REQ-014 An accepted start SHALL latch all three inputs into internal registers.
REQ-015 An accepted start SHALL clear the step count to 0.
REQ-016 An accepted start SHALL load the 12-bit accumulator with {8'b0, inRemainder} when REMAINDER_ADD_EN is defined, else 0.
REQ-017 RUN SHALL last exactly 4 cycles, with the count running 0..3.
REQ-018 On each RUN edge: if the multiplier LSB is 1, the accumulator SHALL add {4'b0, mcand} << count, truncated to 12 bits.
REQ-019 On each RUN edge the multiplier SHALL shift right by 1 and the count SHALL increment.
REQ-020 Arithmetic SHALL be unsigned; truncation never occurs, since the maximum result 255*15+15=3840 < 4096.
REQ-021 Latency SHALL be: start sampled at edge N; done=1 during the cycle after edge N+4.
REQ-022 Dividend SHALL be updated only on the transition into DONE.
REQ-023 Dividend SHALL NOT change during RUN; it keeps the previous result.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 Input changes after acceptance SHALL have no effect on the running operation.
REQ-026 start=1 in DONE SHALL be accepted back-to-back: done=1 and busy=0 in that cycle, then busy=1 on the next cycle.
REQ-027 inDivisor=0 SHALL yield Dividend=inRemainder (or 0 without the macro) after the normal 4-cycle latency, with no early exit.

Reset
REQ-028 resetn=0 at a rising edge SHALL force state=IDLE, busy=0, done=0, Dividend=0, and clear the count, accumulator and latched operands.
REQ-029 A reset taken mid-RUN SHALL abort the operation with no done pulse.
REQ-030 resetn=0 SHALL dominate a simultaneous start.

Configuration
REQ-031 Macro FIXED_MUL_REMAINDER_ADD_EN defined: Dividend = inQuotient*inDivisor + inRemainder, the exact inverse of fixed_divider.
REQ-032 Macro undefined: Dividend = inQuotient*inDivisor; the inRemainder port is kept but ignored.
REQ-033 Latency SHALL be identical in both builds.

Structure
REQ-034 Package fixed_mul_pkg SHALL hold the width constants (QW=8, DW=4, RW=4, PW=12), the step-count constant 4 and the FSM state typedef.
REQ-035 One combinational sub-module, fixed_mul_step, SHALL compute the conditional shifted add for one step (inputs: acc, mcand, bit, count; output: next acc).

Verification
REQ-036 Macro on: 255, 15, 15 -> Dividend=3840, done exactly 5 cycles after start; macro off -> 3825.
REQ-037 Macro on: 160, 13, 3 -> 2083; it SHALL match fixed_divider(2083, 13) = (160, 3) in a loopback with the divider.
REQ-038 Macro on: inDivisor=0, inRemainder=5, any quotient -> 5 after 4 RUN cycles.
REQ-039 start pulsed during RUN cycle 2 with different operands -> first result unaffected and no second operation.
REQ-040 resetn=0 in RUN cycle 3 -> next cycle busy=0, done=0, Dividend=0, IDLE; a following start computes normally.
REQ-041 Two operations with start held high through DONE -> done pulses 5 cycles apart with correct results; the exhaustive 8x4x4 sweep matches the reference model.

Source files
------------

// File: rtl/fixed_mul_pkg.sv
// -----------------------------------------------------------------------------
// fixed_mul_pkg
//
// Shared constants, FSM state encoding and the partial-product helper for the
// fixed_multiplier shift-and-add datapath.
//
//   QW    : multiplicand (quotient) width       = 8
//   DW    : multiplier (divisor) width          = 4
//   RW    : addend (remainder) width            = 4
//   PW    : product (dividend) width            = 12
//   STEPS : number of RUN cycles per operation  = 4 (one per multiplier bit)
//   CW    : width of the step counter
//
// The FSM state is a plain 2-bit vector type with named constants so the
// encoding stays stable for tools and netlists that expect fixed codes.
// -----------------------------------------------------------------------------
package fixed_mul_pkg;

  localparam int QW    = 8;
  localparam int DW    = 4;
  localparam int RW    = 4;
  localparam int PW    = 12;
  localparam int STEPS = 4;
  localparam int CW    = $clog2(STEPS);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Multiplicand zero-extended to the product width and weighted by the
  // position of the multiplier bit currently being consumed.
  function automatic logic [PW-1:0] partial_product(
    input logic [QW-1:0] mcand,
    input logic [CW-1:0] count
  );
    logic [PW-1:0] ext;
    ext = {{(PW-QW){1'b0}}, mcand};
    return ext << count;
  endfunction

endpackage : fixed_mul_pkg

// File: rtl/fixed_mul_step.sv
// -----------------------------------------------------------------------------
// fixed_mul_step
//
// Purely combinational single step of the shift-and-add multiplier. When the
// current multiplier bit is set, the multiplicand shifted by the step index is
// added to the running accumulator; otherwise the accumulator passes through.
// The sum wraps at PW bits, which can never happen for in-range operands.
//
// Ports:
//   acc_i    [PW-1:0]  running accumulator
//   mcand_i  [QW-1:0]  latched multiplicand
//   bit_i              multiplier bit for this step (LSB of the shifted copy)
//   count_i  [CW-1:0]  step index, i.e. the weight of bit_i
//   acc_o    [PW-1:0]  accumulator after this step
// -----------------------------------------------------------------------------
module fixed_mul_step
  import fixed_mul_pkg::*;
(
  input  logic [PW-1:0] acc_i,
  input  logic [QW-1:0] mcand_i,
  input  logic          bit_i,
  input  logic [CW-1:0] count_i,
  output logic [PW-1:0] acc_o
);

  logic [PW-1:0] addend;

  always_comb begin
    addend = '0;
    if (bit_i) begin
      addend = partial_product(mcand_i, count_i);
    end
    acc_o = acc_i + addend;
  end

endmodule : fixed_mul_step

// File: rtl/fixed_multiplier.sv
// -----------------------------------------------------------------------------
// fixed_multiplier
//
// Sequential unsigned multiplier, the inverse of fixed_divider:
//   Dividend = inQuotient * inDivisor (+ inRemainder when
//   FIXED_MUL_REMAINDER_ADD_EN is defined).
// One multiplier bit is consumed per RUN cycle, so every operation takes
// exactly four RUN cycles regardless of operand values; the latency is the
// same in both builds, only the accumulator preload differs.
//
// Configuration macro:
//   FIXED_MUL_REMAINDER_ADD_EN  defined   -> accumulator preloaded with
//                                            inRemainder
//                               undefined -> preloaded with zero, inRemainder
//                                            latched but otherwise ignored
//
// Ports:
//   clock              rising-edge clock for all state
//   resetn             synchronous active-low reset (dominates start)
//   start              request, sampled in IDLE or DONE only
//   inQuotient  [7:0]  multiplicand, latched on an accepted start
//   inDivisor   [3:0]  multiplier, latched on an accepted start
//   inRemainder [3:0]  addend, latched on an accepted start
//   busy               high while in RUN
//   done               one-cycle pulse in DONE, when Dividend becomes valid
//   Dividend   [11:0]  result, held from done until the next result
//
// Timing: start accepted at edge N -> RUN edges N+1..N+4 -> done high during
// the cycle following edge N+4. A start seen in DONE is accepted immediately,
// so back-to-back operations complete every five cycles.
// -----------------------------------------------------------------------------
module fixed_multiplier
  import fixed_mul_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [QW-1:0] inQuotient,
  input  logic [DW-1:0] inDivisor,
  input  logic [RW-1:0] inRemainder,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] Dividend
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        state_q,    state_d;
  logic [CW-1:0] count_q,    count_d;
  logic [PW-1:0] acc_q,      acc_d;
  logic [QW-1:0] mcand_q,    mcand_d;
  logic [DW-1:0] mplier_q,   mplier_d;
  logic [RW-1:0] rem_q,      rem_d;
  logic [PW-1:0] dividend_q, dividend_d;

  // Accumulator value after the current RUN step.
  logic [PW-1:0] step_acc;

  // Value loaded into the accumulator when an operation is accepted.
  logic [PW-1:0] acc_preload;

`ifdef FIXED_MUL_REMAINDER_ADD_EN
  assign acc_preload = {{(PW-RW){1'b0}}, inRemainder};
`else
  assign acc_preload = '0;
`endif

  // The latched addend only ever reaches the result through the accumulator
  // preload; the register is kept so all operands are captured uniformly.
  logic unused_rem;
  assign unused_rem = ^rem_q;

  // ---------------------------------------------------------------------------
  // Datapath step
  // ---------------------------------------------------------------------------
  fixed_mul_step u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bit_i   (mplier_q[0]),
    .count_i (count_q),
    .acc_o   (step_acc)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    dividend_d = dividend_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          count_d  = '0;
          acc_d    = acc_preload;
          mcand_d  = inQuotient;
          mplier_d = inDivisor;
          rem_d    = inRemainder;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // start is deliberately not looked at here: requests while busy are
        // dropped, and the latched operands are the only ones in use.
        acc_d    = step_acc;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(STEPS - 1)) begin
          // Last step: publish the completed sum together with the DONE
          // transition so Dividend never shows a partial result.
          state_d    = ST_DONE;
          dividend_d = step_acc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      dividend_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      dividend_q <= dividend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign Dividend = dividend_q;

endmodule : fixed_multiplier

// File: tb/tb_fixed_multiplier.sv
// -----------------------------------------------------------------------------
// tb_fixed_multiplier
//
// Scoreboard bench for fixed_multiplier. Each operation pushes its expected
// Dividend when start is driven; the entry is popped and compared when done
// appears. Expected values follow FIXED_MUL_REMAINDER_ADD_EN when defined.
// -----------------------------------------------------------------------------
module tb_fixed_multiplier;

`ifdef FIXED_MUL_REMAINDER_ADD_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  inQuotient = '0;
  logic [3:0]  inDivisor = '0;
  logic [3:0]  inRemainder = '0;
  logic        busy;
  logic        done;
  logic [11:0] Dividend;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];

  always #5 clock = ~clock;

  fixed_multiplier u_dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .inQuotient  (inQuotient),
    .inDivisor   (inDivisor),
    .inRemainder (inRemainder),
    .busy        (busy),
    .done        (done),
    .Dividend    (Dividend)
  );

  // Reference: plain integer multiply-add.
  function automatic logic [11:0] ref_mul(input logic [7:0] q, input logic [3:0] d,
                                          input logic [3:0] r);
    int p;
    p = int'(q) * int'(d) + (REM_EN ? int'(r) : 0);
    return 12'(p);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one accepted start (one edge) and record the expected result.
  task automatic start_op(input logic [7:0] q, input logic [3:0] d,
                          input logic [3:0] r, input logic [11:0] expv);
    inQuotient  = q;
    inDivisor   = d;
    inRemainder = r;
    start       = 1'b1;
    exp_q.push_back(expv);
    tick();
    start = 1'b0;
  endtask

  // Advance until done is seen or the cycle budget runs out.
  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    resetn      = 1'b0;
    start       = 1'b1;
    inQuotient  = 8'd77;
    inDivisor   = 4'd3;
    inRemainder = 4'd1;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (Dividend !== 12'd0) begin n_err++; $display("FAIL reset_dividend: got %0d want 0", Dividend); end
    start  = 1'b0;
    resetn = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    $display("reset: busy=%b done=%b Dividend=%0d", busy, done, Dividend);
  endtask

  task automatic test_max();
    int cyc; bit ok; logic [11:0] e;
    start_op(8'd255, 4'd15, 4'd15, REM_EN ? 12'd3840 : 12'd3825);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL max_busy: got busy=%b done=%b want 1/0", busy, done); end
    wait_done(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || cyc != 4) begin n_err++; $display("FAIL max_latency: got %0d edges (ok=%0b) want 4", cyc, ok); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL max_busy_done: got %b want 0", busy); end
    n_cmp++; if (Dividend !== e) begin n_err++; $display("FAIL max_result: got %0d want %0d", Dividend, e); end
    $display("max: 255*15+15 -> Dividend=%0d expected=%0d latency=%0d", Dividend, e, cyc);
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL max_pulse: done got %b want 0", done); end
    n_cmp++; if (Dividend !== e) begin n_err++; $display("FAIL max_hold: got %0d want %0d", Dividend, e); end
  endtask

  // Dividend must keep the previous result throughout RUN.
  task automatic test_hold_loopback();
    logic [11:0] prev, e; int i;
    prev = REM_EN ? 12'd3840 : 12'd3825;
    start_op(8'd160, 4'd13, 4'd3, REM_EN ? 12'd2083 : 12'd2080);
    i = 0;
    while (done !== 1'b1 && i < 20) begin
      n_cmp++; if (Dividend !== prev) begin n_err++; $display("FAIL hold_run: cycle %0d got %0d want %0d", i, Dividend, prev); end
      tick();
      i++;
    end
    e = exp_q.pop_front();
    n_cmp++; if (done !== 1'b1 || i != 4) begin n_err++; $display("FAIL hold_latency: got %0d edges want 4", i); end
    n_cmp++; if (Dividend !== e) begin n_err++; $display("FAIL loop_result: got %0d want %0d", Dividend, e); end
`ifdef FIXED_MUL_REMAINDER_ADD_EN
    // Divider model: 2083 / 13 must give back quotient 160, remainder 3.
    n_cmp++; if (int'(Dividend) / 13 != 160 || int'(Dividend) % 13 != 3) begin
      n_err++; $display("FAIL loop_divider: got q=%0d r=%0d want q=160 r=3", int'(Dividend) / 13, int'(Dividend) % 13);
    end
`endif
    $display("loopback: 160*13(+3) -> Dividend=%0d expected=%0d", Dividend, e);
    tick();
  endtask

  task automatic test_zero_divisor();
    int cyc; bit ok; logic [11:0] e;
    start_op(8'hA7, 4'd0, 4'd5, REM_EN ? 12'd5 : 12'd0);
    wait_done(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || cyc != 4) begin n_err++; $display("FAIL zero_latency: got %0d edges want 4", cyc); end
    n_cmp++; if (Dividend !== e) begin n_err++; $display("FAIL zero_result: got %0d want %0d", Dividend, e); end
    $display("zero divisor: 167*0(+5) -> Dividend=%0d expected=%0d", Dividend, e);
    tick();
  endtask

  task automatic test_ignore_start();
    int cyc; bit ok; bit extra; logic [11:0] e;
    start_op(8'd100, 4'd7, 4'd2, REM_EN ? 12'd702 : 12'd700);
    tick();
    inQuotient  = 8'd33;
    inDivisor   = 4'd3;
    inRemainder = 4'd9;
    start       = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || cyc != 2) begin n_err++; $display("FAIL ignore_latency: got %0d edges want 2", cyc); end
    n_cmp++; if (Dividend !== e) begin n_err++; $display("FAIL ignore_result: got %0d want %0d", Dividend, e); end
    extra = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    n_cmp++; if (extra) begin n_err++; $display("FAIL ignore_second_op: got extra activity want none"); end
    $display("ignore start: 100*7(+2) -> Dividend=%0d expected=%0d", Dividend, e);
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit ok; bit spurious; logic [11:0] e;
    start_op(8'd200, 4'd9, 4'd4, ref_mul(8'd200, 4'd9, 4'd4));
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    void'(exp_q.pop_back());
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_flags: got busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if (Dividend !== 12'd0) begin n_err++; $display("FAIL midrst_dividend: got %0d want 0", Dividend); end
    spurious = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    n_cmp++; if (spurious) begin n_err++; $display("FAIL midrst_no_done: got activity after abort want none"); end
    start_op(8'd12, 4'd11, 4'd6, REM_EN ? 12'd138 : 12'd132);
    wait_done(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || cyc != 4) begin n_err++; $display("FAIL midrst_latency: got %0d edges want 4", cyc); end
    n_cmp++; if (Dividend !== e) begin n_err++; $display("FAIL midrst_result: got %0d want %0d", Dividend, e); end
    $display("reset mid-run: then 12*11(+6) -> Dividend=%0d expected=%0d", Dividend, e);
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2; bit ok; logic [11:0] e;
    inQuotient  = 8'd50;
    inDivisor   = 4'd15;
    inRemainder = 4'd9;
    start       = 1'b1;
    exp_q.push_back(REM_EN ? 12'd759 : 12'd750);
    tick();
    // start stays high; these operands are picked up only from DONE.
    inQuotient  = 8'd201;
    inDivisor   = 4'd14;
    inRemainder = 4'd1;
    exp_q.push_back(REM_EN ? 12'd2815 : 12'd2814);
    wait_done(cyc1, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || cyc1 != 4) begin n_err++; $display("FAIL b2b_latency1: got %0d edges want 4", cyc1); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_done: got %b want 0", busy); end
    n_cmp++; if (Dividend !== e) begin n_err++; $display("FAIL b2b_result1: got %0d want %0d", Dividend, e); end
    $display("back-to-back #1: 50*15(+9) -> Dividend=%0d expected=%0d", Dividend, e);
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_restart: got busy=%b done=%b want 1/0", busy, done); end
    wait_done(cyc2, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || cyc2 + 1 != 5) begin n_err++; $display("FAIL b2b_spacing: got %0d cycles want 5", cyc2 + 1); end
    n_cmp++; if (Dividend !== e) begin n_err++; $display("FAIL b2b_result2: got %0d want %0d", Dividend, e); end
    $display("back-to-back #2: 201*14(+1) -> Dividend=%0d expected=%0d", Dividend, e);
    tick();
  endtask

  // All multipliers and addends against corner and random multiplicands,
  // issued back-to-back from DONE.
  task automatic test_sweep();
    int cyc; bit ok; logic [11:0] e; logic [7:0] q; int errs_before;
    errs_before = n_err;
    for (int d = 0; d < 16; d++) begin
      for (int r = 0; r < 16; r++) begin
        for (int k = 0; k < 5; k++) begin
          case (k)
            0:       q = 8'd0;
            1:       q = 8'd255;
            2:       q = 8'd128;
            default: q = 8'($urandom_range(1, 254));
          endcase
          start_op(q, 4'(d), 4'(r), ref_mul(q, 4'(d), 4'(r)));
          wait_done(cyc, ok);
          e = exp_q.pop_front();
          n_cmp++;
          if (!ok || Dividend !== e) begin
            n_err++;
            $display("FAIL sweep q=%0d d=%0d r=%0d: got %0d (done=%0b) want %0d", q, d, r, Dividend, ok, e);
          end
        end
      end
    end
    tick();
    $display("sweep: 1280 operations, %0d errors", n_err - errs_before);
  endtask

  initial begin
    test_reset();
    test_max();
    test_hold_loopback();
    test_zero_divisor();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_fixed_multiplier
